// File: rtl/instr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_trace_buffer
// Purpose  : Retire-trace recorder for the 16-bit WISC core. Each committed
//            instruction is captured ({pc, instr, taken, target}) into a
//            circular buffer. The buffer is drained through a first-word
//            fall-through valid/ready port. Per-opcode retire counters and a
//            saturating drop counter are kept alongside.
// Macro    : TRACE_FILTER_EN - adds filter_mask[15:0]. An entry is stored
//            only when filter_mask[opcode] is set.
// Ports    : clk, rst_n (async, active-low), en, clr (sync clear)
//            ret_vld/ret_instr/ret_pc/ret_taken/ret_target : retire input
//            rd_rdy in, rd_vld/rd_instr/rd_pc/rd_taken/rd_target out : FWFT read
//            count, overflow, drop_cnt : occupancy and loss status
//            cnt_sel in, cnt_val out : per-opcode counter readout (comb)
//            halted : high once an HLT has retired, until clr
// Revision : 1.0 - initial release
// ============================================================================
module instr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16,
  parameter int OVERWRITE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef TRACE_FILTER_EN
  input  logic [15:0]                filter_mask,
`endif
  input  logic                       en,
  input  logic                       clr,
  input  logic                       ret_vld,
  input  logic [15:0]                ret_instr,
  input  logic [ADDR_W-1:0]          ret_pc,
  input  logic                       ret_taken,
  input  logic [ADDR_W-1:0]          ret_target,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [15:0]                rd_instr,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic                       rd_taken,
  output logic [ADDR_W-1:0]          rd_target,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic [3:0]                 cnt_sel,
  output logic [CNT_W-1:0]           cnt_val,
  output logic                       halted
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam int                   OCC_W    = $clog2(DEPTH + 1);
  localparam int                   ENT_W    = 2 * ADDR_W + 17;
  localparam logic [OCC_W-1:0]     FULL_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam bit                   OVW      = (OVERWRITE != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   opc_cnt_q [16];
  logic [CNT_W-1:0]   opc_cnt_d [16];
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic [3:0]         opcode;
  logic               capture;
  logic               store;
  logic               pop;
  logic               full;
  logic               is_branch;
  logic               wr_en;
  logic [ENT_W-1:0]   entry;

  assign opcode    = ret_instr[15:12];
  assign capture   = ret_vld && (state_q == S_RUN) && !clr;
`ifdef TRACE_FILTER_EN
  assign store     = capture && filter_mask[opcode];
`else
  assign store     = capture;
`endif
  assign pop       = (count_q != '0) && rd_rdy;
  assign full      = (count_q == FULL_OCC);
  // A full buffer still accepts a write when a pop frees a slot this cycle,
  // or when the oldest entry may be sacrificed.
  assign wr_en     = store && (!full || pop || OVW);
  assign is_branch = (opcode == 4'hC) || (opcode == 4'hD);
  assign entry     = {ret_pc, ret_instr, is_branch & ret_taken,
                      is_branch ? ret_target : {ADDR_W{1'b0}}};

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (en) state_d = S_RUN;
        S_RUN: begin
          // HLT is captured first, so it wins over a simultaneous en drop
          if (capture && (opcode == 4'hF)) state_d = S_HALTED;
          else if (!en)                    state_d = S_IDLE;
        end
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Buffer bookkeeping and counters
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    for (int i = 0; i < 16; i++) opc_cnt_d[i] = opc_cnt_q[i];

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      for (int i = 0; i < 16; i++) opc_cnt_d[i] = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      // Overwriting a full buffer without a pop evicts the oldest entry
      if (pop || (wr_en && full)) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (store && !pop && !full)   count_d = count_q + OCC_W'(1);
      else if (pop && !store)       count_d = count_q - OCC_W'(1);

      if (store && full && !pop) begin
        overflow_d = 1'b1;
        if (drop_q != CNT_MAX) drop_d = drop_q + CNT_W'(1);
      end

      if (capture && (opc_cnt_q[opcode] != CNT_MAX))
        opc_cnt_d[opcode] = opc_cnt_q[opcode] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < 16; i++)    opc_cnt_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i]     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      for (int i = 0; i < 16; i++) opc_cnt_q[i] <= opc_cnt_d[i];
      if (wr_en) mem_q[wr_ptr_q] <= entry;
    end
  end

  assign rd_vld   = (count_q != '0);
  assign {rd_pc, rd_instr, rd_taken, rd_target} = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign cnt_val  = opc_cnt_q[cnt_sel];
  assign halted   = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_trace_buffer
// Purpose  : Randomised self-checking bench for instr_trace_buffer. Two
//            instances (overwrite-oldest and discard-newest, DEPTH=4, 4-bit
//            counters) share one stimulus stream and are compared every cycle
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_trace_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int CW    = 4;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        taken;
    logic [15:0] tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, ret_vld = 1'b0, ret_taken = 1'b0, rd_rdy = 1'b0;
  logic [15:0] ret_instr = '0;
  logic [AW-1:0] ret_pc = '0, ret_target = '0;
  logic [3:0] cnt_sel = '0;
`ifdef TRACE_FILTER_EN
  logic [15:0] filter_mask = 16'hFFFF;
`endif

  logic          vld_o   [2];
  logic [15:0]   instr_o [2];
  logic [AW-1:0] pc_o    [2];
  logic          taken_o [2];
  logic [AW-1:0] tgt_o   [2];
  logic [OW-1:0] count_o [2];
  logic          ovf_o   [2];
  logic [CW-1:0] drop_o  [2];
  logic [CW-1:0] cval_o  [2];
  logic          halt_o  [2];

  always #5 clk = ~clk;

  instr_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW), .OVERWRITE(1)) u_ovw (
    .clk(clk), .rst_n(rst_n),
`ifdef TRACE_FILTER_EN
    .filter_mask(filter_mask),
`endif
    .en(en), .clr(clr), .ret_vld(ret_vld), .ret_instr(ret_instr), .ret_pc(ret_pc),
    .ret_taken(ret_taken), .ret_target(ret_target), .rd_rdy(rd_rdy),
    .rd_vld(vld_o[0]), .rd_instr(instr_o[0]), .rd_pc(pc_o[0]), .rd_taken(taken_o[0]),
    .rd_target(tgt_o[0]), .count(count_o[0]), .overflow(ovf_o[0]), .drop_cnt(drop_o[0]),
    .cnt_sel(cnt_sel), .cnt_val(cval_o[0]), .halted(halt_o[0])
  );

  instr_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW), .OVERWRITE(0)) u_dsc (
    .clk(clk), .rst_n(rst_n),
`ifdef TRACE_FILTER_EN
    .filter_mask(filter_mask),
`endif
    .en(en), .clr(clr), .ret_vld(ret_vld), .ret_instr(ret_instr), .ret_pc(ret_pc),
    .ret_taken(ret_taken), .ret_target(ret_target), .rd_rdy(rd_rdy),
    .rd_vld(vld_o[1]), .rd_instr(instr_o[1]), .rd_pc(pc_o[1]), .rd_taken(taken_o[1]),
    .rd_target(tgt_o[1]), .count(count_o[1]), .overflow(ovf_o[1]), .drop_cnt(drop_o[1]),
    .cnt_sel(cnt_sel), .cnt_val(cval_o[1]), .halted(halt_o[1])
  );

  // Reference model: 0 = idle, 1 = run, 2 = halted
  ent_t mq     [2][$];
  int   m_st   [2];
  int   m_cnt  [2][16];
  int   m_drop [2];
  bit   m_ovf  [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    mq[k].delete();
    m_st[k]   = 0;
    m_drop[k] = 0;
    m_ovf[k]  = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   op;
      bit   cap, keep, pop;
      ent_t e;
      op  = int'(ret_instr[15:12]);
      cap = ret_vld && (m_st[k] == 1) && !clr;
      if (clr) begin
        model_reset(k);
        continue;
      end
      pop = (mq[k].size() != 0) && rd_rdy;
      if (cap && m_cnt[k][op] < CMAX) m_cnt[k][op]++;
      keep = cap;
`ifdef TRACE_FILTER_EN
      keep = keep && filter_mask[op];
`endif
      if (pop) void'(mq[k].pop_front());
      if (keep) begin
        e.pc    = ret_pc;
        e.instr = ret_instr;
        e.taken = (op == 12 || op == 13) ? ret_taken : 1'b0;
        e.tgt   = (op == 12 || op == 13) ? ret_target : '0;
        if (mq[k].size() < DEPTH) mq[k].push_back(e);
        else begin
          m_ovf[k] = 1'b1;
          if (m_drop[k] < CMAX) m_drop[k]++;
          if (k == 0) begin
            void'(mq[k].pop_front());
            mq[k].push_back(e);
          end
        end
      end
      case (m_st[k])
        0: if (en) m_st[k] = 1;
        1: if (cap && op == 15) m_st[k] = 2; else if (!en) m_st[k] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      string p;
      ent_t  e;
      p = (k == 0) ? "ovw" : "dsc";
      check({p, ".rd_vld"}, vld_o[k], mq[k].size() != 0);
      check({p, ".count"}, count_o[k], mq[k].size());
      if (mq[k].size() != 0) begin
        e = mq[k][0];
        check({p, ".rd_pc"}, pc_o[k], e.pc);
        check({p, ".rd_instr"}, instr_o[k], e.instr);
        check({p, ".rd_taken"}, taken_o[k], e.taken);
        check({p, ".rd_target"}, tgt_o[k], e.tgt);
      end
      check({p, ".overflow"}, ovf_o[k], m_ovf[k]);
      check({p, ".drop_cnt"}, drop_o[k], m_drop[k]);
      check({p, ".halted"}, halt_o[k], m_st[k] == 2);
      check({p, ".cnt_val"}, cval_o[k], m_cnt[k][cnt_sel]);
    end
  endtask

  task automatic check_zero_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst.rd_pc", pc_o[k], 0);
      check("rst.rd_instr", instr_o[k], 0);
      check("rst.rd_taken", taken_o[k], 0);
      check("rst.rd_target", tgt_o[k], 0);
    end
  endtask

  // Inputs are set at a falling edge; outputs are checked 1 time unit later
  // and the model advances across the following rising edge.
  task automatic step();
    #1 compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit e, input bit c, input bit v, input logic [15:0] ins,
                       input logic [15:0] pc, input bit tk, input logic [15:0] tg,
                       input bit rdy, input logic [3:0] sel);
    en = e; clr = c; ret_vld = v; ret_instr = ins; ret_pc = pc;
    ret_taken = tk; ret_target = tg; rd_rdy = rdy; cnt_sel = sel;
    step();
  endtask

  initial begin
    int phase_rdy, phase_clr;
    logic [3:0] op;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    #1 compare_all();
    check_zero_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: ADD, SUB then drain; B taken, ADD with taken, HLT, extra retire
    drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 4'h0);
    drive(1, 0, 1, 16'h0123, 16'h0000, 0, 16'h0000, 0, 4'h0);
    drive(1, 0, 1, 16'h1456, 16'h0002, 0, 16'h0000, 0, 4'h1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 4'(i));
    drive(1, 0, 1, 16'hC010, 16'h0010, 1, 16'h0040, 0, 4'hC);
    drive(1, 0, 1, 16'h0321, 16'h0012, 1, 16'h0099, 0, 4'h0);
    drive(1, 0, 1, 16'hF000, 16'h0014, 0, 16'h0000, 0, 4'hF);
    drive(1, 0, 1, 16'h2222, 16'h0016, 0, 16'h0000, 0, 4'h2);
    drive(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 4'hF);
    drive(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 4'hF);
    // Directed: fill past full with no reads, then drain
    drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 4'h0);
    for (int i = 0; i < 6; i++) drive(1, 0, 1, 16'h3000, 16'(2 * i), 0, 16'h0, 0, 4'h3);
    drive(1, 0, 1, 16'h4000, 16'h0020, 0, 16'h0000, 1, 4'h4);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0, 1, 4'h3);
    drive(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 4'h0);

    // Randomised phases
    phase_rdy = 50;
    phase_clr = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 60 == 0) begin
        phase_rdy = $urandom_range(5, 90);
        phase_clr = ($urandom_range(0, 2) == 0) ? 0 : 1;
`ifdef TRACE_FILTER_EN
        case ($urandom_range(0, 2))
          0: filter_mask = 16'hFFFF;
          1: filter_mask = 16'h3000;
          default: filter_mask = 16'($urandom);
        endcase
`endif
      end
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 79) == 0) op = 4'hF;
      en        = ($urandom_range(0, 99) < 95);
      clr       = phase_clr != 0 && ($urandom_range(0, 59) == 0);
      ret_vld   = ($urandom_range(0, 99) < 70);
      ret_instr = {op, 12'($urandom)};
      ret_pc    = {15'($urandom), 1'b0};
      ret_taken = 1'($urandom);
      ret_target = 16'($urandom);
      rd_rdy    = ($urandom_range(0, 99) < phase_rdy);
      cnt_sel   = 4'($urandom);
      step();
      if (cyc == 800 || cyc == 1200) begin
        // Asynchronous reset between edges, checked before the next edge
        #2 rst_n = 1'b0;
        #1 model_reset(0);
        model_reset(1);
        compare_all();
        check_zero_outputs();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_trace_buffer.md
Name: instr_trace_buffer

Overview:
- Synthesisable retire-trace recorder for the 16-bit WISC core.
- Captures each committed instruction (PC, raw instruction word, branch outcome and target) into a parametrised circular buffer.
- Keeps per-opcode retire counters and drains entries through a valid/ready read port to a debug unit or bench monitor.
- Replaces the bench-only, string-based instruction display with hardware that is visible in synthesis and in simulation.

Parameters:
- DEPTH, 16, buffer entries; power of 2, minimum 2.
- ADDR_W, 16, PC and branch-target width.
- CNT_W, 16, width of the per-opcode counters and the drop counter.
- OVERWRITE, 1, full-buffer policy: 1 = overwrite oldest entry, 0 = discard newest entry.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  trace enable
- clr  in  1  synchronous clear
- ret_vld  in  1  retire strobe, one instruction per cycle
- ret_instr  in  16  retired instruction; opcode = [15:12]
- ret_pc  in  ADDR_W  PC of the retired instruction
- ret_taken  in  1  branch actually taken
- ret_target  in  ADDR_W  actual branch target
- rd_rdy  in  1  consumer ready
- rd_vld  out  1  head entry valid
- rd_instr  out  16  head entry instruction word
- rd_pc  out  ADDR_W  head entry PC
- rd_taken  out  1  head entry taken flag
- rd_target  out  ADDR_W  head entry target
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky; set when any entry has been lost
- drop_cnt  out  CNT_W  number of lost entries, saturating
- cnt_sel  in  4  opcode selector for counter readout
- cnt_val  out  CNT_W  retire count for opcode cnt_sel, combinational
- halted  out  1  high in state HALTED

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. On reset, state = IDLE; pointers, count, overflow, drop_cnt and all 16 opcode counters = 0; rd_vld = 0; halted = 0; rd_* data outputs = 0.
- States and transitions (clr has priority over all other inputs):
  - IDLE: en=1 → RUN.
  - RUN: en=0 → IDLE. An accepted HLT (opcode 0xF) → HALTED on the next edge.
  - HALTED: clr → IDLE. en has no effect in HALTED.
- Capture condition: ret_vld=1 and state=RUN, evaluated at the clock edge; the entry is visible on the read side one cycle later.
  - Stored fields: {pc, instr, taken, target}.
  - For opcodes other than 0xC and 0xD, taken and target are stored as 0.
  - The HLT instruction itself is captured.
- Opcode counters: on every capture, counter[opcode] increments, saturating at 2^CNT_W-1. Counters increment even when the entry is dropped.
- Read side (first-word fall-through):
  - rd_vld = (count != 0); rd_* = mem[rd_ptr].
  - Pop when rd_vld & rd_rdy.
  - Reads are allowed in every state.
- Occupancy: count tracks pushes minus pops. Pointers wrap modulo DEPTH.
- Full buffer (count = DEPTH) with a capture and no pop:
  - OVERWRITE=1: write at wr_ptr, advance both pointers, count stays DEPTH, overflow=1, drop_cnt++.
  - OVERWRITE=0: discard the new entry, overflow=1, drop_cnt++.
- Full buffer with simultaneous pop and capture: no drop; count stays DEPTH.
- Empty buffer with simultaneous capture and rd_rdy: no pop, because rd_vld=0 in that cycle.
- clr: next edge sets state=IDLE; pointers, count, counters, overflow and drop_cnt return to 0. Any capture in the same cycle is ignored.
- Reset mid-operation: everything cleared immediately; buffered entries are lost.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined: adds input filter_mask [15:0]. An entry is stored only if filter_mask[opcode]=1. Opcode counters still count every capture. A filtered-out HLT still causes the transition to HALTED. Filtered-out entries are not counted as drops.
- Undefined: no filter_mask port; every capture is stored.

Test Plan:
- Basic capture and drain: reset, en=1, retire ADD(0x0123)@PC 0x0000, SUB(0x1456)@0x0002, then rd_rdy=1 → drain yields them in order, count 2→0, rd_vld falls after the second pop, cnt_val(sel=0)=1, cnt_val(sel=1)=1.
- Overwrite on full (DEPTH=4, OVERWRITE=1): 6 retires @PC 0x0,0x2,…,0xA, no reads → drain yields PCs 0x4,0x6,0x8,0xA; overflow=1; drop_cnt=2.
- Discard on full (DEPTH=4, OVERWRITE=0): same stimulus → drain yields PCs 0x0,0x2,0x4,0x6; drop_cnt=2.
- Full with simultaneous pop and push: buffer full, pop and push in the same cycle → count stays 4, drop_cnt unchanged, new entry arrives last.
- Branch and halt: B taken to 0x0040, then ADD with ret_taken=1 asserted, then HLT, then a further retire → B entry has taken=1, target=0x0040; ADD entry has taken=0, target=0; HLT is stored; halted=1; the further retire is ignored; clr → IDLE and count=0.
- Async reset mid-operation: assert rst_n low between clock edges while 3 entries are buffered → rd_vld, count and counters read 0 immediately; with TRACE_FILTER_EN and filter_mask=16'h3000 → only opcode 0xC and 0xD entries are stored.
